// File: rtl/booth_mult8_arbiter_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM encoding,
// pointer-width helper, core latency helper and Booth recoding helper.
package booth_mult8_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Width of an index into n requesters (never below one bit).
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Cycles from core start to core done for a given operand width.
    function automatic int core_latency(input int width);
        return width + 2;
    endfunction

    // Radix-2 Booth recoding of the current multiplier bit pair.
    function automatic booth_op_t booth_op(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b10:   return BOOTH_SUB;
            2'b01:   return BOOTH_ADD;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult8_arbiter_core.sv
// Iterative radix-2 Booth multiplier. Operands are extended by one bit
// (sign or zero, per sign_mode) so all four sign combinations share one
// signed datapath. done pulses core_latency(WIDTH) cycles after start.
module booth_mult8_core
    import booth_mult8_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           sign_mode,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);

    logic [N:0]    mcand;
    logic [N:0]    acc;
    logic [N:0]    next_acc;
    logic [N-1:0]  q;
    logic          qm1;
    logic [CW-1:0] cnt;
    logic          running;

    // Add or subtract the multiplicand according to the Booth bit pair.
    always_comb begin
        next_acc = acc;
        case (booth_op(q[0], qm1))
            BOOTH_ADD: next_acc = acc + mcand;
            BOOTH_SUB: next_acc = acc - mcand;
            default:   next_acc = acc;
        endcase
    end

    // Load on start, then one add/shift step per cycle for N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= {{2{sign_mode[1] & a[WIDTH-1]}}, a};
                acc     <= '0;
                q       <= {sign_mode[0] & b[WIDTH-1], b};
                qm1     <= 1'b0;
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                acc <= {next_acc[N], next_acc[N:1]};
                q   <= {next_acc[0], q[N-1:1]};
                qm1 <= q[0];
                cnt <= cnt + 1'b1;
                if (cnt == CW'(N - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    // Low 2*WIDTH bits of the signed product are exact for every sign mode.
    assign product = {acc[WIDTH-2:0], q};

endmodule

// File: rtl/booth_mult8_arbiter.sv
// Round-robin arbiter in front of a single Booth multiplier core.
// Handshake: a requester is accepted in the cycle where req_valid[i] and
// req_ready[i] are both high; a result is consumed in the cycle where
// rsp_valid and rsp_ready are both high. req_ready is only offered in IDLE.
module booth_mult8_arbiter
    import booth_mult8_arbiter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]         req_a,
    input  logic [NUM_REQ*WIDTH-1:0]         req_b,
    input  logic [2*NUM_REQ-1:0]             req_sign_mode,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ptr_width(NUM_REQ)-1:0]    rsp_id,
    output logic [2*WIDTH-1:0]               rsp_product,
    output logic                             busy,
    output logic [1:0]                       fsm_state
);

    localparam int IDW = ptr_width(NUM_REQ);

    arb_state_t         state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     lat_id;
    logic [WIDTH-1:0]   lat_a;
    logic [WIDTH-1:0]   lat_b;
    logic [1:0]         lat_sign;
    logic               core_start;
    logic               core_done;
    logic [2*WIDTH-1:0] core_product;
    logic               found;
    logic [IDW-1:0]     gnt_idx;
    int                 idx;

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    // One-hot accept strobe, only while idle.
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && found) req_ready[gnt_idx] = 1'b1;
    end

    // Transaction FSM: grant, start the core, wait for done, hold response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            lat_id      <= '0;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_sign    <= '0;
            core_start  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        lat_id     <= gnt_idx;
                        lat_a      <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                        lat_b      <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                        lat_sign   <= req_sign_mode[int'(gnt_idx)*2 +: 2];
                        ptr        <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        core_start <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    core_start <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        rsp_product <= core_product;
                        rsp_id      <= lat_id;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    booth_mult8_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (core_start),
        .a         (lat_a),
        .b         (lat_b),
        .sign_mode (lat_sign),
        .done      (core_done),
        .product   (core_product)
    );

endmodule

// File: tb/tb_booth_mult8_arbiter.sv
// Self-checking bench for booth_mult8_arbiter: a cycle-level transaction
// model (round-robin pick, fixed latency, plain-arithmetic product) checked
// every cycle, plus directed cases with hand-computed literals.
module tb_booth_mult8_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int LAT     = 10;  // core start -> done for WIDTH=8

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*WIDTH-1:0]  req_a;
    logic [NUM_REQ*WIDTH-1:0]  req_b;
    logic [2*NUM_REQ-1:0]      req_sign_mode;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [1:0]                rsp_id;
    logic [2*WIDTH-1:0]        rsp_product;
    logic                      busy;
    logic [1:0]                fsm_state;

    // Clock
    always #5 clk = ~clk;

    booth_mult8_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_sign_mode (req_sign_mode),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_product   (rsp_product),
        .busy          (busy),
        .fsm_state     (fsm_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Exact product from plain integer arithmetic.
    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] s);
        longint va, vb;
        va = s[1] ? longint'($signed(a)) : longint'(a);
        vb = s[0] ? longint'($signed(b)) : longint'(b);
        return 16'(va * vb);
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    bit          m_inflight = 0;
    int          m_cyc = 0;
    int          m_tg = 0;
    int          m_p = 0;
    int          m_g;
    logic [1:0]  m_id;
    logic [15:0] m_prod;
    logic [3:0]  m_rdy;
    logic        m_rv;

    always @(negedge clk) begin
        m_cyc++;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_rsp_product", 32'(rsp_product), 0);
            m_inflight = 0;
            m_p = 0;
        end else if (!m_inflight) begin
            m_g   = rr_pick(req_valid, m_p);
            m_rdy = (m_g >= 0) ? 4'(1 << m_g) : 4'd0;
            chk("model_req_ready", 32'(req_ready), 32'(m_rdy));
            chk("model_busy_idle", 32'(busy), 0);
            chk("model_rsp_valid_idle", 32'(rsp_valid), 0);
            if (m_g >= 0) begin
                m_inflight = 1;
                m_tg   = m_cyc;
                m_id   = 2'(m_g);
                m_prod = ref_prod(req_a[m_g*8 +: 8], req_b[m_g*8 +: 8], req_sign_mode[m_g*2 +: 2]);
                m_p    = (m_g + 1) % NUM_REQ;
            end
        end else begin
            m_rv = ((m_cyc - m_tg) >= LAT + 2);
            chk("model_req_ready_busy", 32'(req_ready), 0);
            chk("model_busy", 32'(busy), 1);
            chk("model_rsp_valid", 32'(rsp_valid), 32'(m_rv));
            if (m_rv) begin
                chk("model_rsp_id", 32'(rsp_id), 32'(m_id));
                chk("model_rsp_product", 32'(rsp_product), 32'(m_prod));
                if (rsp_ready) m_inflight = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] s);
        req_a[i*8 +: 8]         = a;
        req_b[i*8 +: 8]         = b;
        req_sign_mode[i*2 +: 2] = s;
        req_valid[i]            = 1'b1;
    endtask

    task automatic wait_grant(output int g, output time t);
        g = -1;
        t = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
                t = $time;
                break;
            end
        end
        if (g < 0) timeout("wait_grant");
    endtask

    task automatic wait_rsp(output logic [15:0] p, output logic [1:0] id, output time t);
        bit seen;
        seen = 0;
        p = '0;
        id = '0;
        t = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                p = rsp_product;
                id = rsp_id;
                t = $time;
                seen = 1;
                break;
            end
        end
        if (!seen) timeout("wait_rsp");
    endtask

    // ---------------- stimulus ----------------
    int          g;
    time         t0, t1;
    logic [15:0] p0;
    logic [1:0]  id0;
    int          gr[5];
    int          rs[5];
    int          exp_order[5] = '{0, 1, 2, 3, 0};
    int          ng, nr, cnt;
    bit          done_flag;

    initial begin
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_sign_mode = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Signed x signed: -3 * 5
        set_req(0, 8'hFD, 8'h05, 2'b11);
        wait_grant(g, t0);
        chk("t1_grant", 32'(g), 0);
        @(posedge clk); #1;
        req_valid = '0;
        req_a = $urandom;
        req_b = $urandom;
        wait_rsp(p0, id0, t1);
        chk("t1_product", 32'(p0), 32'h0000FFF1);
        chk("t1_id", 32'(id0), 0);
        chk("t1_latency", 32'((t1 - t0) / 10), 12);

        // Unsigned x unsigned: 255 * 255
        @(posedge clk); #1;
        set_req(2, 8'hFF, 8'hFF, 2'b00);
        wait_grant(g, t0);
        chk("t2_grant", 32'(g), 2);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(p0, id0, t1);
        chk("t2_product", 32'(p0), 32'h0000FE01);
        chk("t2_id", 32'(id0), 2);

        // Signed A x unsigned B: -128 * 255
        @(posedge clk); #1;
        set_req(1, 8'h80, 8'hFF, 2'b10);
        wait_grant(g, t0);
        chk("t3_grant", 32'(g), 1);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(p0, id0, t1);
        chk("t3_product", 32'(p0), 32'h00008080);
        chk("t3_id", 32'(id0), 1);

        // Round-robin order after reset with all requesters valid
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
        ng = 0;
        nr = 0;
        for (int n = 0; n < 300 && !(ng == 5 && nr == 5); n++) begin
            @(negedge clk);
            if (req_ready != 0 && ng < 5) begin
                for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) gr[ng] = k;
                ng++;
            end
            if (rsp_valid && rsp_ready && nr < 5) begin
                rs[nr] = int'(rsp_id);
                nr++;
            end
        end
        if (ng < 5 || nr < 5) timeout("rr_order");
        for (int k = 0; k < 5; k++) begin
            if (k < ng) chk($sformatf("rr_grant_%0d", k), 32'(gr[k]), 32'(exp_order[k]));
            if (k < nr) chk($sformatf("rr_rsp_id_%0d", k), 32'(rs[k]), 32'(exp_order[k]));
        end

        // Consumer stall with other requests pending
        @(posedge clk); #1 rsp_ready = 1'b0;
        wait_rsp(p0, id0, t1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_product", 32'(rsp_product), 32'(p0));
            chk("stall_id", 32'(rsp_id), 32'(id0));
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_req_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        cnt = 0;
        done_flag = 0;
        for (int n = 0; n < 20 && !done_flag; n++) begin
            @(negedge clk);
            cnt++;
            if (req_ready != 0) done_flag = 1;
        end
        chk("stall_next_grant_negedges", 32'(cnt), 2);

        // Reset during WAIT aborts the transaction
        @(posedge clk); #1 req_valid = '0;
        done_flag = 0;
        for (int n = 0; n < 100 && !done_flag; n++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) done_flag = 1;
        end
        if (!done_flag) timeout("drain_idle");
        @(posedge clk); #1;
        set_req(1, 8'h11, 8'h22, 2'b00);
        wait_grant(g, t0);
        chk("rst_pre_grant", 32'(g), 1);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(1, 8'h7F, 8'h81, 2'b11);
        set_req(3, 8'($urandom), 8'($urandom), 2'($urandom));
        wait_grant(g, t0);
        chk("rst_first_grant", 32'(g), 1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_rsp(p0, id0, t1);
        chk("rst_post_product", 32'(p0), 32'h0000C0FF);
        chk("rst_post_id", 32'(id0), 1);

        // Randomized traffic; operands change every cycle, even in flight
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            req_valid     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            req_a         = $urandom;
            req_b         = $urandom;
            req_sign_mode = 8'($urandom);
            rsp_ready     = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (30) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
